cordic_arb: RTL
===============

CORDIC_ARB -- requirements
Module: cordic_arb

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 16, data width of angle and sin/cos (Q4.12).
REQ-002 SHALL have parameter N_CH, default 4, number of requesting channels, range 2..8.
REQ-003 SHALL have parameter TIMEOUT, default 64, maximum cycles to wait for the core result.
REQ-004 SHALL have port sys_clk  input  1  clock; all logic on the rising edge.
REQ-005 SHALL have port sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  N_CH  per-channel request pending.
REQ-007 SHALL have port req_theta  input  N_CH*BIT_WIDTH  per-channel angle; channel i occupies bits [i*BIT_WIDTH +: BIT_WIDTH].
REQ-008 SHALL have port req_ready  output  N_CH  one-hot accept strobe; a request transfers when req_valid[i] and req_ready[i] are both high.
REQ-009 SHALL have port core_start  output  1  one-cycle start pulse to the CORDIC core.
REQ-010 SHALL have port core_theta  output  BIT_WIDTH  angle to the core, held stable from core_start until the state returns to IDLE.
REQ-011 SHALL have port core_sin, core_cos  input  BIT_WIDTH each  core results.
REQ-012 SHALL have port core_valid  input  1  core result strobe.
REQ-013 SHALL have port rsp_valid  output  1  one-cycle response pulse; there is no back-pressure.
REQ-014 SHALL have port rsp_ch  output  clog2(N_CH)  channel that owns the response.
REQ-015 SHALL have port rsp_sin, rsp_cos  output  BIT_WIDTH each  results, zero when rsp_err is high.
REQ-016 SHALL have port rsp_err  output  1  response terminated by timeout.

Function
REQ-017 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, holding one request in flight at a time.
REQ-018 IDLE SHALL, when any req_valid bit is high, grant exactly one channel by round-robin, searching from rr_ptr upward with wrap-around.
REQ-019 IDLE SHALL drive req_ready combinationally as the one-hot grant and SHALL keep req_ready at zero in every other state.
REQ-020 On accept, the block SHALL latch the granted req_theta and channel, set rr_ptr to (granted+1) mod N_CH, and go to ISSUE.
REQ-021 ISSUE SHALL assert core_start for exactly one cycle, clear the timer, and go to WAIT.
REQ-022 WAIT SHALL increment the timer each cycle.
REQ-023 When core_valid is seen in WAIT, the block SHALL capture core_sin/core_cos, set err=0, and go to RESP.
REQ-024 When the timer reaches TIMEOUT-1 without core_valid, the block SHALL set err=1, zero sin/cos, and go to RESP.
REQ-025 When core_valid and the timeout occur in the same cycle, core_valid SHALL win (err=0).
REQ-026 RESP SHALL drive rsp_valid for one cycle with registered rsp_ch/rsp_sin/rsp_cos/rsp_err, then go to IDLE.
REQ-027 core_valid in IDLE, ISSUE or RESP SHALL be ignored, since it is a stale result from a timed-out operation.
REQ-028 Latency: with accept at cycle T, core_start SHALL occur at T+1; with core_valid at cycle V, rsp_valid SHALL occur at V+1; the next accept SHALL occur no earlier than V+2.
REQ-029 A channel whose req_valid drops before grant SHALL NOT be served; no request buffering occurs beyond the one accepted.

Reset
REQ-030 While sys_rst_n is low, the block SHALL set state IDLE, rr_ptr 0, timer 0, and all outputs (req_ready, core_start, core_theta, rsp_*) to 0.
REQ-031 Reset asserted mid-operation SHALL abort the request in flight without a response; a core_valid arriving after reset SHALL be ignored per REQ-027.

Structure
REQ-032 The shared package cordic_pkg SHALL hold the FSM state encoding, the BIT_WIDTH/N_INT/N_FRAC/K/DEPTH constants (16/4/12/2487/12), and the clog2 function.
REQ-033 The round-robin grant SHALL be a sub-module rr_grant (inputs req, ptr; output one-hot grant and index), instantiated once.
REQ-034 The CORDIC core SHALL be instantiated outside this block.

Verification
REQ-035 Single request: ch2 req_theta=0x0C91 (pi/4) with a core model replying after 14 cycles -> one rsp_valid, rsp_ch=2, rsp_sin=rsp_cos=0x0B50±2 LSB, rsp_err=0.
REQ-036 Fairness: all 4 channels held valid continuously -> grants in order 0,1,2,3,0,1,... with no channel granted twice before each other channel is granted once.
REQ-037 Timeout: core never asserts core_valid -> rsp_valid at accept+1+TIMEOUT+1 with rsp_err=1 and sin=cos=0; a late core_valid is ignored and produces no extra response.
REQ-038 Collision: core_valid asserted exactly on the timeout cycle -> rsp_err=0 with the core data.
REQ-039 Reset mid-WAIT: sys_rst_n pulsed low -> all outputs 0, no response, next grant goes to ch0.
REQ-040 Sweep: 30 angles at 10 steps from a reference table across ch0..3 -> all results match the table within ±2 LSB and every response is tagged with the correct channel.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: FSM encoding, Q4.12 format constants and a
// constant-foldable ceil(log2) helper.
package cordic_pkg;

  localparam int BIT_WIDTH = 16;
  localparam int N_INT     = 4;
  localparam int N_FRAC    = 12;
  localparam int K         = 2487;  // CORDIC gain 0.6073 in Q4.12
  localparam int DEPTH     = 12;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/cordic_arb_rr_grant.sv
// Round-robin grant: picks the first requester at or above ptr, wrapping
// around, and returns it both one-hot and as an index.
module rr_grant
  import cordic_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PTR_W = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] idx
);

  logic w_found;
  int   w_cand;

  always_comb begin
    grant   = '0;
    idx     = '0;
    w_found = 1'b0;
    w_cand  = 0;
    for (int i = 0; i < N_REQ; i++) begin
      w_cand = (int'(ptr) + i) % N_REQ;
      if (!w_found && req[w_cand]) begin
        w_found       = 1'b1;
        grant[w_cand] = 1'b1;
        idx           = PTR_W'(w_cand);
      end
    end
  end

endmodule

// File: rtl/cordic_arb.sv
// Arbitrates N_CH angle requests onto one shared CORDIC core, one request in
// flight, with a result timeout so a hung core cannot stall the requesters.
module cordic_arb #(
  parameter int BIT_WIDTH = 16,
  parameter int N_CH      = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic                              sys_clk,
  input  logic                              sys_rst_n,
  input  logic [N_CH-1:0]                   req_valid,
  input  logic [N_CH*BIT_WIDTH-1:0]         req_theta,
  output logic [N_CH-1:0]                   req_ready,
  output logic                              core_start,
  output logic [BIT_WIDTH-1:0]              core_theta,
  input  logic [BIT_WIDTH-1:0]              core_sin,
  input  logic [BIT_WIDTH-1:0]              core_cos,
  input  logic                              core_valid,
  output logic                              rsp_valid,
  output logic [cordic_pkg::clog2(N_CH)-1:0] rsp_ch,
  output logic [BIT_WIDTH-1:0]              rsp_sin,
  output logic [BIT_WIDTH-1:0]              rsp_cos,
  output logic                              rsp_err
);
  import cordic_pkg::*;

  localparam int CH_W  = clog2(N_CH);
  localparam int TMR_W = clog2(TIMEOUT) + 1;

  state_e               r_state;
  logic [CH_W-1:0]      r_rr_ptr;
  logic [CH_W-1:0]      r_ch;
  logic [TMR_W-1:0]     r_timer;
  logic                 r_core_start;
  logic [BIT_WIDTH-1:0] r_core_theta;
  logic                 r_rsp_valid;
  logic [CH_W-1:0]      r_rsp_ch;
  logic [BIT_WIDTH-1:0] r_rsp_sin;
  logic [BIT_WIDTH-1:0] r_rsp_cos;
  logic                 r_rsp_err;

  logic [N_CH-1:0]      w_grant;
  logic [CH_W-1:0]      w_idx;

  rr_grant #(
    .N_REQ (N_CH),
    .PTR_W (CH_W)
  ) u_rr_grant (
    .req   (req_valid),
    .ptr   (r_rr_ptr),
    .grant (w_grant),
    .idx   (w_idx)
  );

  // Ready is the live grant, masked in reset so nothing transfers while held.
  always_comb begin
    req_ready = '0;
    if (r_state == StIdle && sys_rst_n) req_ready = w_grant;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= StIdle;
      r_rr_ptr     <= '0;
      r_ch         <= '0;
      r_timer      <= '0;
      r_core_start <= 1'b0;
      r_core_theta <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_ch     <= '0;
      r_rsp_sin    <= '0;
      r_rsp_cos    <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (|w_grant) begin
            r_core_theta <= req_theta[int'(w_idx)*BIT_WIDTH +: BIT_WIDTH];
            r_ch         <= w_idx;
            r_rr_ptr     <= (w_idx == CH_W'(N_CH - 1)) ? '0 : w_idx + CH_W'(1);
            r_core_start <= 1'b1;
            r_state      <= StIssue;
          end
        end
        StIssue: begin
          r_core_start <= 1'b0;
          r_timer      <= '0;
          r_state      <= StWait;
        end
        StWait: begin
          // A result on the timeout cycle still counts as a good result.
          if (core_valid) begin
            r_rsp_valid <= 1'b1;
            r_rsp_ch    <= r_ch;
            r_rsp_sin   <= core_sin;
            r_rsp_cos   <= core_cos;
            r_rsp_err   <= 1'b0;
            r_state     <= StResp;
          end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
            r_rsp_valid <= 1'b1;
            r_rsp_ch    <= r_ch;
            r_rsp_sin   <= '0;
            r_rsp_cos   <= '0;
            r_rsp_err   <= 1'b1;
            r_state     <= StResp;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        StResp: begin
          r_rsp_valid <= 1'b0;
          r_state     <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign core_start = r_core_start;
  assign core_theta = r_core_theta;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_ch     = r_rsp_ch;
  assign rsp_sin    = r_rsp_sin;
  assign rsp_cos    = r_rsp_cos;
  assign rsp_err    = r_rsp_err;

endmodule
